laser_shot_controller: RTL and testbench
========================================

// Module: laser_shot_controller
// PURPOSE
//  Upstream driver of the laser bitmap-drawing interface: owns the player's laser shot, launches it on a
//  fire request, moves it up once per video frame, and generates offsetX/offsetY/InsideRectangle for the
//  laser bitmap block each pixel clock. Retires the shot on a hit or at the top of the screen.
//  Sits between the game-control logic and the laser bitmap.
// PARAMETERS
//  OBJECT_WIDTH_X   64   on-screen rectangle width in pixels (32-px bitmap scaled x2)
//  OBJECT_HEIGHT_Y  64   on-screen rectangle height in pixels
//  LAUNCH_Y         400  top-left Y loaded at launch
//  SHIP_X_OFFSET    0    added to shipTopLeftX at launch to get the laser's top-left X
//  SPEED_Y          8    pixels moved up per frame while flying
//  TOP_LIMIT        0    shot retires when its Y would go below this
//  COOLDOWN_FRAMES  15   frames refire is blocked after retirement (only with LASER_COOLDOWN_EN)
// PORTS
//  clk              in   1   pixel clock
//  resetN           in   1   asynchronous active-low reset
//  startOfFrame     in   1   one-cycle pulse per frame
//  pixelX           in   11  current pixel X
//  pixelY           in   11  current pixel Y
//  shipTopLeftX     in   11  ship top-left X; sampled at launch only
//  fireRequest      in   1   level or pulse; sampled every cycle
//  collision        in   1   laser-hit pulse from the collision logic; may arrive any cycle
//  offsetX          out  11  pixelX - laserX when inside, else 0
//  offsetY          out  11  pixelY - laserY when inside, else 0
//  InsideRectangle  out  1   pixel inside the active laser rectangle
//  laserActive      out  1   shot is in flight (FLYING)
//  laserTopLeftX    out  11  current laser top-left X
//  laserTopLeftY    out  11  current laser top-left Y
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; laserTopLeftY = LAUNCH_Y; fire/hit latches cleared; cooldown counter 0.
//  States:
//   IDLE  - fireRequest=1 sets fireLatch -> ARMED.
//   ARMED - on startOfFrame: laserX <= shipTopLeftX + SHIP_X_OFFSET (11-bit wrap), laserY <= LAUNCH_Y,
//           clear fireLatch -> FLYING.
//   FLYING- collision=1 sets hitLatch. On startOfFrame:
//           * hitLatch or collision in this cycle -> retire;
//           * else if laserY < TOP_LIMIT + SPEED_Y -> retire (no underflow ever computed);
//           * else laserY <= laserY - SPEED_Y.
//           Retire = clear hitLatch -> IDLE (or COOLDOWN, see CONFIGURATION).
//  Position registers change only on startOfFrame, so no tearing within a frame.
//  fireRequest outside IDLE is ignored, not queued. collision outside FLYING is ignored.
//  Simultaneous fireRequest and startOfFrame while IDLE -> ARMED; launch waits for the next startOfFrame.
//  Rectangle generation, 1-cycle registered latency:
//   inside = laserActive & pixelX >= laserX & pixelX < laserX + OBJECT_WIDTH_X
//            & pixelY >= laserY & pixelY < laserY + OBJECT_HEIGHT_Y;
//   bounds compared at 12 bits so that no wrap occurs.
//   Cycle N+1: InsideRectangle = inside(N); offsetX/Y = differences (N), or 0 when not inside.
//   Offsets lie in 0..W-1 / 0..H-1; the bitmap block divides them by 2.
//  Total pixel-to-RGB latency with the bitmap is 2 cycles; the downstream merge aligns for it.
//  Reset mid-flight: immediate IDLE, InsideRectangle 0 in the same cycle (asynchronous).
// CONFIGURATION
//  LASER_COOLDOWN_EN defined:
//   retire -> COOLDOWN, counter loaded with COOLDOWN_FRAMES, decremented on each startOfFrame;
//   -> IDLE when it reaches 0; fireRequest in COOLDOWN is ignored.
//  LASER_COOLDOWN_EN undefined:
//   retire -> IDLE directly; no counter logic; COOLDOWN_FRAMES unused.
// TESTING
//  1 fireRequest pulse, shipTopLeftX=100 -> ARMED; next startOfFrame -> FLYING, laserX=100, laserY=400,
//    laserActive=1.
//  2 Flying, 3 startOfFrame pulses, no hit -> laserY = 376; pixel (110,390) one cycle later ->
//    InsideRectangle=1, offsetX=10, offsetY=14.
//  3 collision pulse mid-frame -> laserActive stays 1 until next startOfFrame, then 0; InsideRectangle
//    stays 0 afterwards.
//  4 laserY=8, SPEED_Y=8, TOP_LIMIT=0, startOfFrame -> laserY=0; next startOfFrame -> retire, no wrap
//    to 2040.
//  5 Pixel (163,400) with laserX=100 -> InsideRectangle=1, offsetX=63; pixel (164,400) ->
//    InsideRectangle=0, offsets 0.
//  6 resetN low mid-flight -> all outputs 0 immediately. With LASER_COOLDOWN_EN, fire after a retire is
//    ignored for 15 frames, then accepted.

Source files
------------

// File: rtl/laser_shot_controller_if.sv
// Signal bundle between the game-control side and the laser shot controller.
// The master modport belongs to the game side (frame timing, pixel position,
// ship position, fire/hit events). The slave modport belongs to the controller,
// which returns the rectangle data and the shot position.
interface laser_shot_controller_if;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [10:0] shipTopLeftX;
  logic        fireRequest;
  logic        collision;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic        laserActive;
  logic [10:0] laserTopLeftX;
  logic [10:0] laserTopLeftY;

  modport master (
    output startOfFrame, pixelX, pixelY, shipTopLeftX, fireRequest, collision,
    input  offsetX, offsetY, InsideRectangle, laserActive, laserTopLeftX, laserTopLeftY
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, shipTopLeftX, fireRequest, collision,
    output offsetX, offsetY, InsideRectangle, laserActive, laserTopLeftX, laserTopLeftY
  );
endinterface

// File: rtl/laser_shot_controller.sv
// Laser shot controller: owns the player's single laser shot. A fire request
// arms the shot, the next frame start launches it from the ship, and it climbs
// SPEED_Y pixels per frame until a hit or the top of the screen retires it.
// Each pixel clock it produces the registered rectangle test and offsets for
// the laser bitmap block (one cycle of latency).
// Optional feature macro: LASER_COOLDOWN_EN -- after a retire the shot passes
// through a COOLDOWN state lasting COOLDOWN_FRAMES frames before refire is
// accepted. The COOLDOWN_FRAMES parameter exists only in that build.
module laser_shot_controller #(
  parameter int OBJECT_WIDTH_X  = 64,
  parameter int OBJECT_HEIGHT_Y = 64,
  parameter int LAUNCH_Y        = 400,
  parameter int SHIP_X_OFFSET   = 0,
  parameter int SPEED_Y         = 8,
  parameter int TOP_LIMIT       = 0
`ifdef LASER_COOLDOWN_EN
  ,
  parameter int COOLDOWN_FRAMES = 15
`endif
) (
  input  logic                   clk,
  input  logic                   resetN,
  laser_shot_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    FLYING   = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [10:0] laser_x;
  logic [10:0] laser_y;
  logic        fire_latch;
  logic        hit_latch;

  logic        launch;
  logic        at_top;
  logic        retire;
  logic        move;

  logic        inside_p0;
  logic [10:0] off_x_p0;
  logic [10:0] off_y_p0;
  logic        inside_p1;
  logic [10:0] off_x_p1;
  logic [10:0] off_y_p1;

  // Span test widened to 12 bits so base + size never wraps around 2047.
  function automatic logic in_span(input logic [10:0] pix, input logic [10:0] base,
                                   input logic [11:0] size);
    logic [11:0] pix_w;
    logic [11:0] base_w;
    pix_w  = {1'b0, pix};
    base_w = {1'b0, base};
    return (pix_w >= base_w) && (pix_w < base_w + size);
  endfunction

  // Frame-aligned control strobes; the climb-limit test avoids ever forming laser_y - SPEED_Y below zero.
  always_comb begin
    launch = (state == ARMED) && bus.startOfFrame && fire_latch;
    at_top = ({1'b0, laser_y} < 12'(TOP_LIMIT + SPEED_Y));
    retire = (state == FLYING) && bus.startOfFrame && (hit_latch || bus.collision || at_top);
    move   = (state == FLYING) && bus.startOfFrame && !retire;
  end

`ifdef LASER_COOLDOWN_EN
  localparam int CD_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  logic [CD_W-1:0] cd_cnt;

  // Cooldown counter: loaded on retire, counts frames down while in COOLDOWN.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cd_cnt <= '0;
    end else if (retire) begin
      cd_cnt <= CD_W'(COOLDOWN_FRAMES);
    end else if ((state == COOLDOWN) && bus.startOfFrame && (cd_cnt != '0)) begin
      cd_cnt <= cd_cnt - 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; fire requests are only heard in IDLE, never queued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.fireRequest) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (launch) begin
          state_next = FLYING;
        end
      end
      FLYING: begin
        if (retire) begin
`ifdef LASER_COOLDOWN_EN
          state_next = COOLDOWN;
`else
          state_next = IDLE;
`endif
        end
      end
      COOLDOWN: begin
`ifdef LASER_COOLDOWN_EN
        if ((cd_cnt == '0) || (bus.startOfFrame && (cd_cnt == CD_W'(1)))) begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Fire and hit latches; a retire takes priority over a same-cycle collision.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fire_latch <= 1'b0;
      hit_latch  <= 1'b0;
    end else begin
      if (launch) begin
        fire_latch <= 1'b0;
      end else if ((state == IDLE) && bus.fireRequest) begin
        fire_latch <= 1'b1;
      end
      if (retire) begin
        hit_latch <= 1'b0;
      end else if ((state == FLYING) && bus.collision) begin
        hit_latch <= 1'b1;
      end
    end
  end

  // Shot position: updated only on frame start so a frame never shows a torn shot.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      laser_x <= '0;
      laser_y <= 11'(LAUNCH_Y);
    end else if (launch) begin
      laser_x <= bus.shipTopLeftX + 11'(SHIP_X_OFFSET);
      laser_y <= 11'(LAUNCH_Y);
    end else if (move) begin
      laser_y <= laser_y - 11'(SPEED_Y);
    end
  end

  // Stage p0: rectangle test and offsets against the current pixel.
  always_comb begin
    inside_p0 = (state == FLYING)
                && in_span(bus.pixelX, laser_x, 12'(OBJECT_WIDTH_X))
                && in_span(bus.pixelY, laser_y, 12'(OBJECT_HEIGHT_Y));
    off_x_p0  = inside_p0 ? (bus.pixelX - laser_x) : 11'd0;
    off_y_p0  = inside_p0 ? (bus.pixelY - laser_y) : 11'd0;
  end

  // Stage p1: registered rectangle outputs; async reset clears them at once.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inside_p1 <= 1'b0;
      off_x_p1  <= '0;
      off_y_p1  <= '0;
    end else begin
      inside_p1 <= inside_p0;
      off_x_p1  <= off_x_p0;
      off_y_p1  <= off_y_p0;
    end
  end

  assign bus.InsideRectangle = inside_p1;
  assign bus.offsetX         = off_x_p1;
  assign bus.offsetY         = off_y_p1;
  assign bus.laserActive     = (state == FLYING);
  assign bus.laserTopLeftX   = laser_x;
  assign bus.laserTopLeftY   = laser_y;

endmodule

// File: tb/tb_laser_shot_controller.sv
// Directed self-checking bench for laser_shot_controller. Also covers the
// LASER_COOLDOWN_EN build when that macro is defined for both files.
module tb_laser_shot_controller;
  logic clk;
  logic resetN;
  int   checks;
  int   errors;

  laser_shot_controller_if bus ();

  laser_shot_controller dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
  endtask

  task automatic set_pixel(input int x, input int y);
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
  endtask

  task automatic wait_cooldown();
`ifdef LASER_COOLDOWN_EN
    repeat (15) sof();
`endif
  endtask

  task automatic launch_at(input int x);
    bus.shipTopLeftX = 11'(x);
    bus.fireRequest  = 1'b1;
    tick();
    bus.fireRequest  = 1'b0;
    sof();
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.fireRequest  = 1'b0;
    bus.collision    = 1'b0;
    bus.shipTopLeftX = '0;
    set_pixel(0, 0);
    repeat (2) tick();
    checks++;
    if (bus.laserActive !== 1'b0 || bus.InsideRectangle !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: active=%0b inside=%0b, want 0/0", bus.laserActive, bus.InsideRectangle);
    end
    checks++;
    if (bus.offsetX !== 11'd0 || bus.offsetY !== 11'd0) begin
      errors++;
      $display("FAIL reset_offsets: got %0d/%0d, want 0/0", bus.offsetX, bus.offsetY);
    end
    checks++;
    if (bus.laserTopLeftX !== 11'd0 || bus.laserTopLeftY !== 11'd400) begin
      errors++;
      $display("FAIL reset_pos: got %0d/%0d, want 0/400", bus.laserTopLeftX, bus.laserTopLeftY);
    end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_launch();
    bus.shipTopLeftX = 11'd100;
    bus.fireRequest  = 1'b1;
    tick();
    bus.fireRequest  = 1'b0;
    checks++;
    if (bus.laserActive !== 1'b0) begin
      errors++;
      $display("FAIL armed_inactive: active=%0b, want 0", bus.laserActive);
    end
    // a hit while merely armed must be ignored
    bus.collision = 1'b1;
    tick();
    bus.collision = 1'b0;
    bus.shipTopLeftX = 11'd100;
    sof();
    checks++;
    if (bus.laserActive !== 1'b1 || bus.laserTopLeftX !== 11'd100 || bus.laserTopLeftY !== 11'd400) begin
      errors++;
      $display("FAIL launch: active=%0b x=%0d y=%0d, want 1/100/400",
               bus.laserActive, bus.laserTopLeftX, bus.laserTopLeftY);
    end
  endtask

  task automatic test_move();
    // fire while flying is ignored and must not relaunch
    bus.fireRequest = 1'b1;
    bus.shipTopLeftX = 11'd500;
    repeat (3) sof();
    bus.fireRequest = 1'b0;
    checks++;
    if (bus.laserTopLeftY !== 11'd376 || bus.laserTopLeftX !== 11'd100) begin
      errors++;
      $display("FAIL move: x=%0d y=%0d, want 100/376", bus.laserTopLeftX, bus.laserTopLeftY);
    end
    set_pixel(110, 390);
    tick();
    checks++;
    if (bus.InsideRectangle !== 1'b1 || bus.offsetX !== 11'd10 || bus.offsetY !== 11'd14) begin
      errors++;
      $display("FAIL pixel_110_390: inside=%0b off=%0d/%0d, want 1/10/14",
               bus.InsideRectangle, bus.offsetX, bus.offsetY);
    end
  endtask

  task automatic test_edges();
    set_pixel(163, 400);
    tick();
    checks++;
    if (bus.InsideRectangle !== 1'b1 || bus.offsetX !== 11'd63 || bus.offsetY !== 11'd24) begin
      errors++;
      $display("FAIL right_edge_in: inside=%0b off=%0d/%0d, want 1/63/24",
               bus.InsideRectangle, bus.offsetX, bus.offsetY);
    end
    set_pixel(164, 400);
    tick();
    checks++;
    if (bus.InsideRectangle !== 1'b0 || bus.offsetX !== 11'd0 || bus.offsetY !== 11'd0) begin
      errors++;
      $display("FAIL right_edge_out: inside=%0b off=%0d/%0d, want 0/0/0",
               bus.InsideRectangle, bus.offsetX, bus.offsetY);
    end
    set_pixel(99, 390);
    tick();
    checks++;
    if (bus.InsideRectangle !== 1'b0) begin
      errors++;
      $display("FAIL left_edge_out: inside=%0b, want 0", bus.InsideRectangle);
    end
    set_pixel(100, 439);
    tick();
    checks++;
    if (bus.InsideRectangle !== 1'b1 || bus.offsetX !== 11'd0 || bus.offsetY !== 11'd63) begin
      errors++;
      $display("FAIL bottom_edge_in: inside=%0b off=%0d/%0d, want 1/0/63",
               bus.InsideRectangle, bus.offsetX, bus.offsetY);
    end
    set_pixel(100, 440);
    tick();
    checks++;
    if (bus.InsideRectangle !== 1'b0) begin
      errors++;
      $display("FAIL bottom_edge_out: inside=%0b, want 0", bus.InsideRectangle);
    end
  endtask

  task automatic test_collision();
    bus.collision = 1'b1;
    tick();
    bus.collision = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.laserActive !== 1'b1 || bus.laserTopLeftY !== 11'd376) begin
      errors++;
      $display("FAIL hit_midframe: active=%0b y=%0d, want 1/376", bus.laserActive, bus.laserTopLeftY);
    end
    sof();
    checks++;
    if (bus.laserActive !== 1'b0) begin
      errors++;
      $display("FAIL hit_retire: active=%0b, want 0", bus.laserActive);
    end
    set_pixel(110, 390);
    repeat (2) tick();
    checks++;
    if (bus.InsideRectangle !== 1'b0 || bus.offsetX !== 11'd0) begin
      errors++;
      $display("FAIL after_hit_rect: inside=%0b offx=%0d, want 0/0", bus.InsideRectangle, bus.offsetX);
    end
  endtask

  task automatic test_top();
    wait_cooldown();
    launch_at(200);
    repeat (49) sof();
    checks++;
    if (bus.laserTopLeftY !== 11'd8 || bus.laserActive !== 1'b1) begin
      errors++;
      $display("FAIL top_y8: y=%0d active=%0b, want 8/1", bus.laserTopLeftY, bus.laserActive);
    end
    sof();
    checks++;
    if (bus.laserTopLeftY !== 11'd0 || bus.laserActive !== 1'b1) begin
      errors++;
      $display("FAIL top_y0: y=%0d active=%0b, want 0/1", bus.laserTopLeftY, bus.laserActive);
    end
    sof();
    checks++;
    if (bus.laserActive !== 1'b0 || bus.laserTopLeftY !== 11'd0) begin
      errors++;
      $display("FAIL top_retire: active=%0b y=%0d, want 0/0", bus.laserActive, bus.laserTopLeftY);
    end
  endtask

  task automatic test_back_to_back();
    wait_cooldown();
    // fire together with a frame start only arms; launch is on the following frame start
    bus.shipTopLeftX = 11'd300;
    bus.fireRequest  = 1'b1;
    bus.startOfFrame = 1'b1;
    tick();
    bus.fireRequest  = 1'b0;
    bus.startOfFrame = 1'b0;
    checks++;
    if (bus.laserActive !== 1'b0) begin
      errors++;
      $display("FAIL fire_with_sof: active=%0b, want 0", bus.laserActive);
    end
    sof();
    checks++;
    if (bus.laserActive !== 1'b1 || bus.laserTopLeftX !== 11'd300) begin
      errors++;
      $display("FAIL fire_with_sof_launch: active=%0b x=%0d, want 1/300", bus.laserActive, bus.laserTopLeftX);
    end
    // collision in the very frame-start cycle retires immediately
    bus.collision    = 1'b1;
    bus.startOfFrame = 1'b1;
    tick();
    bus.collision    = 1'b0;
    bus.startOfFrame = 1'b0;
    checks++;
    if (bus.laserActive !== 1'b0 || bus.laserTopLeftY !== 11'd400) begin
      errors++;
      $display("FAIL hit_on_sof: active=%0b y=%0d, want 0/400", bus.laserActive, bus.laserTopLeftY);
    end
  endtask

`ifdef LASER_COOLDOWN_EN
  task automatic test_cooldown();
    // previous test just retired the shot; every fire in the next 15 frames is dropped
    for (int i = 0; i < 15; i++) begin
      bus.fireRequest = 1'b1;
      tick();
      bus.fireRequest = 1'b0;
      sof();
      checks++;
      if (bus.laserActive !== 1'b0) begin
        errors++;
        $display("FAIL cooldown_block frame %0d: active=%0b, want 0", i, bus.laserActive);
      end
    end
    launch_at(50);
    checks++;
    if (bus.laserActive !== 1'b1 || bus.laserTopLeftX !== 11'd50) begin
      errors++;
      $display("FAIL cooldown_accept: active=%0b x=%0d, want 1/50", bus.laserActive, bus.laserTopLeftX);
    end
    bus.collision = 1'b1;
    tick();
    bus.collision = 1'b0;
    sof();
  endtask
`endif

  task automatic test_reset_midflight();
    wait_cooldown();
    launch_at(100);
    set_pixel(110, 410);
    tick();
    checks++;
    if (bus.InsideRectangle !== 1'b1 || bus.offsetY !== 11'd10) begin
      errors++;
      $display("FAIL prereset_inside: inside=%0b offy=%0d, want 1/10", bus.InsideRectangle, bus.offsetY);
    end
    #2;
    resetN = 1'b0;
    #1;
    checks++;
    if (bus.InsideRectangle !== 1'b0 || bus.laserActive !== 1'b0 ||
        bus.offsetX !== 11'd0 || bus.offsetY !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: inside=%0b active=%0b off=%0d/%0d, want 0/0/0/0",
               bus.InsideRectangle, bus.laserActive, bus.offsetX, bus.offsetY);
    end
    checks++;
    if (bus.laserTopLeftX !== 11'd0 || bus.laserTopLeftY !== 11'd400) begin
      errors++;
      $display("FAIL async_reset_pos: x=%0d y=%0d, want 0/400", bus.laserTopLeftX, bus.laserTopLeftY);
    end
    tick();
    resetN = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_launch();
    test_move();
    test_edges();
    test_collision();
    test_top();
    test_back_to_back();
`ifdef LASER_COOLDOWN_EN
    test_cooldown();
`endif
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
